mem_arbiter_np: RTL and testbench

//  N-requester memory access controller with one preemptive priority requester.

---
 rtl/mem_arbiter_np.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter_np.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_np.sv
// Memory access arbiter: requester 0 may preempt a low-priority owner; the others share access round-robin.
// Owners are bounded by per-class hold limits and the preemptions are counted.
module mem_arbiter_np #(
   parameter int NUM_REQ       = 3,
   parameter int LIMIT_LO      = 2,
   parameter int LIMIT_PREEMPT = 2,
   parameter int CNT_W         = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           done,
   output logic [$clog2(NUM_REQ+1)-1:0] acc_module,
   output logic [2:0]                   state_oh,
   output logic [CNT_W-1:0]             nb_interrupts,
   output logic                         limit_expired
);

   localparam int ID_W     = $clog2(NUM_REQ + 1);
   localparam int IDX_W    = $clog2(NUM_REQ);
   localparam int HOLD_MAX = (LIMIT_LO > LIMIT_PREEMPT) ? LIMIT_LO : LIMIT_PREEMPT;
   localparam int HC_W     = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {IDLE, OWN_HI, OWN_LO, PREEMPT} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     saved_q, saved_d;
   logic [IDX_W-1:0]     rr_q, rr_d;
   logic [HC_W-1:0]      hold_q, hold_d;
   logic [NUM_REQ-1:0]   pend_q, pend_d;
   logic [CNT_W-1:0]     nb_q, nb_d;
   logic                 expired_q, expired_d;
   logic [ID_W-1:0]      acc_q, acc_d;
   logic [2:0]           oh_q, oh_d;

   logic [NUM_REQ-1:0]   req_v, eff, excl, cand;
   logic                 pick_ok, grant_lo;
   logic [IDX_W-1:0]     pick_idx, idx;

   function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] k);
      return (int'(k) >= NUM_REQ - 1) ? IDX_W'(1) : k + IDX_W'(1);
   endfunction

   // A req paired with its own done is dropped, as is req[0] while M1 already holds memory.
   always_comb begin
      req_v = req & ~done;
      if (state_q == OWN_HI || state_q == PREEMPT) req_v[0] = 1'b0;
      eff = pend_q | req_v;
   end

   always_comb begin
      excl = '0;
      if (state_q == OWN_LO) excl[owner_q] = 1'b1;
      cand     = eff & ~excl;
      pick_ok  = 1'b0;
      pick_idx = '0;
      idx      = '0;
      for (int off = NUM_REQ - 2; off >= 0; off--) begin
         idx = IDX_W'((int'(rr_q) - 1 + off) % (NUM_REQ - 1) + 1);
         if (cand[idx]) begin
            pick_ok  = 1'b1;
            pick_idx = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      saved_d   = saved_q;
      rr_d      = rr_q;
      hold_d    = hold_q + HC_W'(1);
      pend_d    = pend_q | req_v;
      nb_d      = nb_q;
      expired_d = 1'b0;
      grant_lo  = 1'b0;
      case (state_q)
         IDLE: begin
            hold_d = '0;
            if (eff[0]) begin
               state_d   = OWN_HI;
               owner_d   = '0;
               pend_d[0] = 1'b0;
            end else if (pick_ok) begin
               grant_lo = 1'b1;
            end
         end
         OWN_HI: begin
            hold_d = '0;
            if (done[0]) begin
               if (pick_ok) grant_lo = 1'b1;
               else         state_d  = IDLE;
            end
         end
         OWN_LO: begin
            if (eff[0] && !done[owner_q]) begin
               state_d   = PREEMPT;
               saved_d   = owner_q;
               owner_d   = '0;
               hold_d    = '0;
               pend_d[0] = 1'b0;
               if (nb_q != '1) nb_d = nb_q + CNT_W'(1);
            end else if (done[owner_q] || hold_q == HC_W'(LIMIT_LO - 1)) begin
               // Re-queueing the expired owner lets it win again, but only after an idle cycle.
               if (!done[owner_q]) begin
                  pend_d[owner_q] = 1'b1;
                  expired_d       = 1'b1;
               end
               if (eff[0]) begin
                  state_d   = OWN_HI;
                  owner_d   = '0;
                  hold_d    = '0;
                  pend_d[0] = 1'b0;
               end else if (pick_ok) begin
                  grant_lo = 1'b1;
               end else begin
                  state_d = IDLE;
                  hold_d  = '0;
               end
            end
         end
         PREEMPT: begin
            if (done[0] || hold_q == HC_W'(LIMIT_PREEMPT - 1)) begin
               expired_d       = !done[0];
               state_d         = OWN_LO;
               owner_d         = saved_q;
               hold_d          = '0;
               pend_d[saved_q] = 1'b0;
               rr_d            = next_rr(saved_q);
            end
         end
         default: state_d = IDLE;
      endcase
      if (grant_lo) begin
         state_d          = OWN_LO;
         owner_d          = pick_idx;
         hold_d           = '0;
         pend_d[pick_idx] = 1'b0;
         rr_d             = next_rr(pick_idx);
      end
   end

   always_comb begin
      acc_d = (state_d == IDLE) ? '0 : ID_W'(owner_d) + ID_W'(1);
      case (state_d)
         OWN_HI:  oh_d = 3'b001;
         OWN_LO:  oh_d = 3'b010;
         PREEMPT: oh_d = 3'b100;
         default: oh_d = 3'b000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         saved_q   <= '0;
         rr_q      <= IDX_W'(1);
         hold_q    <= '0;
         pend_q    <= '0;
         nb_q      <= '0;
         expired_q <= 1'b0;
         acc_q     <= '0;
         oh_q      <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         saved_q   <= saved_d;
         rr_q      <= rr_d;
         hold_q    <= hold_d;
         pend_q    <= pend_d;
         nb_q      <= nb_d;
         expired_q <= expired_d;
         acc_q     <= acc_d;
         oh_q      <= oh_d;
      end
   end

   assign acc_module    = acc_q;
   assign state_oh      = oh_q;
   assign nb_interrupts = nb_q;
   assign limit_expired = expired_q;

endmodule

// File: tb/tb_mem_arbiter_np.sv
// Directed bench for mem_arbiter_np (3 requesters, 2-cycle limits, 2-bit preemption counter).
// Each vector drives one cycle of req/done and checks the registered outputs 1 ns after the edge.
module tb_mem_arbiter_np;

   logic       clock = 1'b0;
   logic       resetN;
   logic [2:0] req;
   logic [2:0] done;
   logic [1:0] accModule;
   logic [2:0] stateOh;
   logic [1:0] nbInterrupts;
   logic       limitExpired;

   int vecCount  = 0;
   int missCount = 0;

   mem_arbiter_np #(
      .NUM_REQ      (3),
      .LIMIT_LO     (2),
      .LIMIT_PREEMPT(2),
      .CNT_W        (2)
   ) dut (
      .clk          (clock),
      .reset_n      (resetN),
      .req          (req),
      .done         (done),
      .acc_module   (accModule),
      .state_oh     (stateOh),
      .nb_interrupts(nbInterrupts),
      .limit_expired(limitExpired)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic checkArb(input string tag, input int accExp, input int ohExp, input int expExp);
      checkOutput({tag, ".acc"}, 32'(accModule), accExp);
      checkOutput({tag, ".oh"}, 32'(stateOh), ohExp);
      checkOutput({tag, ".lim"}, 32'(limitExpired), expExp);
   endtask

   // Drives one cycle of pulses, then returns 1 ns after the edge that consumed them.
   task automatic applyStimulus(input logic [2:0] r, input logic [2:0] d);
      req  = r;
      done = d;
      @(posedge clock);
      #1;
      req  = '0;
      done = '0;
   endtask

   task automatic doReset();
      resetN = 1'b0;
      req    = '0;
      done   = '0;
      repeat (2) @(posedge clock);
      #1;
      checkArb("reset", 0, 0, 0);
      checkOutput("reset.nb", 32'(nbInterrupts), 0);
      resetN = 1'b1;
   endtask

   initial begin
      doReset();

      // Test 1: M1 owns without limit and releases on done[0].
      applyStimulus(3'b001, 3'b000);
      checkArb("t1.grant", 1, 1, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(3'b000, 3'b000);
         checkOutput("t1.hold", 32'(accModule), 1);
      end
      applyStimulus(3'b001, 3'b000);
      checkArb("t1.reqIgnored", 1, 1, 0);
      applyStimulus(3'b000, 3'b001);
      checkArb("t1.release", 0, 0, 0);
      applyStimulus(3'b000, 3'b000);
      checkArb("t1.staysIdle", 0, 0, 0);

      // Test 2: two low requesters alternate on the hold limit.
      applyStimulus(3'b110, 3'b000);
      checkArb("t2.c0", 2, 2, 0);
      applyStimulus(3'b000, 3'b000);
      checkArb("t2.c1", 2, 2, 0);
      applyStimulus(3'b000, 3'b000);
      checkArb("t2.c2", 3, 2, 1);
      applyStimulus(3'b000, 3'b000);
      checkArb("t2.c3", 3, 2, 0);
      applyStimulus(3'b000, 3'b000);
      checkArb("t2.c4", 2, 2, 1);
      applyStimulus(3'b000, 3'b000);
      checkArb("t2.c5", 2, 2, 0);
      applyStimulus(3'b000, 3'b000);
      checkArb("t2.c6", 3, 2, 1);
      applyStimulus(3'b000, 3'b100);
      checkArb("t2.done2", 2, 2, 0);
      applyStimulus(3'b000, 3'b010);
      checkArb("t2.done1", 0, 0, 0);
      checkOutput("t2.nb", 32'(nbInterrupts), 0);

      // Test 3: M1 preempts requester 1 on its limit cycle, then is forced off.
      applyStimulus(3'b010, 3'b000);
      checkArb("t3.c0", 2, 2, 0);
      applyStimulus(3'b000, 3'b000);
      checkArb("t3.c1", 2, 2, 0);
      applyStimulus(3'b001, 3'b000);
      checkArb("t3.preempt", 1, 4, 0);
      checkOutput("t3.nb", 32'(nbInterrupts), 1);
      applyStimulus(3'b000, 3'b000);
      checkArb("t3.m1hold", 1, 4, 0);
      applyStimulus(3'b000, 3'b000);
      checkArb("t3.restore", 2, 2, 1);
      applyStimulus(3'b000, 3'b000);
      checkArb("t3.resHold", 2, 2, 0);
      applyStimulus(3'b000, 3'b000);
      checkArb("t3.idleGap", 0, 0, 1);
      applyStimulus(3'b000, 3'b000);
      checkArb("t3.regrant", 2, 2, 0);
      applyStimulus(3'b000, 3'b010);
      checkArb("t3.release", 0, 0, 0);
      checkOutput("t3.nbKept", 32'(nbInterrupts), 1);

      // Test 4: M1 hands over straight to a low requester with no idle cycle.
      applyStimulus(3'b001, 3'b000);
      checkArb("t4.grant", 1, 1, 0);
      applyStimulus(3'b100, 3'b001);
      checkArb("t4.handover", 3, 2, 0);
      applyStimulus(3'b000, 3'b100);
      checkArb("t4.release", 0, 0, 0);

      // Test 5: preemption counter saturates at 3.
      doReset();
      for (int i = 1; i <= 7; i++) begin
         applyStimulus(3'b010, 3'b000);
         checkArb("t5.lo", 2, 2, 0);
         applyStimulus(3'b001, 3'b000);
         checkArb("t5.pre", 1, 4, 0);
         checkOutput("t5.nb", 32'(nbInterrupts), (i < 3) ? i : 3);
         applyStimulus(3'b000, 3'b001);
         checkArb("t5.back", 2, 2, 0);
         applyStimulus(3'b000, 3'b010);
         checkArb("t5.idle", 0, 0, 0);
      end

      // Test 6: asynchronous reset between edges while requester 1 owns and 2 is pending.
      applyStimulus(3'b010, 3'b000);
      checkArb("t6.own", 2, 2, 0);
      applyStimulus(3'b100, 3'b000);
      checkArb("t6.pend", 2, 2, 0);
      #2;
      resetN = 1'b0;
      #1;
      checkArb("t6.async", 0, 0, 0);
      checkOutput("t6.nb", 32'(nbInterrupts), 0);
      #1;
      resetN = 1'b1;
      applyStimulus(3'b000, 3'b000);
      checkArb("t6.lost0", 0, 0, 0);
      applyStimulus(3'b000, 3'b000);
      checkArb("t6.lost1", 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
